// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: per-bit direction, output latches, input
// synchronisers and rise/fall edge interrupts with write-1-to-clear pending.
module gpio_bank #(
  parameter int WIDTH       = 8,
  parameter int NUM_PORTS   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SEL_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SEL_W-1:0]           sel,
  input  logic [WIDTH-1:0]           wrData,
  input  logic                       ceOut,
  input  logic                       ceDir,
  input  logic                       ceRise,
  input  logic                       ceFall,
  input  logic                       clrIrq,
  input  logic [1:0]                 rdSrc,
  output logic [WIDTH-1:0]           rdData,
  input  logic [NUM_PORTS*WIDTH-1:0] padIn,
  output logic [NUM_PORTS*WIDTH-1:0] padOut,
  output logic [NUM_PORTS*WIDTH-1:0] padOe,
  output logic [NUM_PORTS-1:0]       irqPend,
  output logic                       irq
);

  localparam int N = NUM_PORTS * WIDTH;

  logic [N-1:0] out_q;
  logic [N-1:0] dir_q;
  logic [N-1:0] rise_en_q;
  logic [N-1:0] fall_en_q;
  logic [N-1:0] pend_q;
  logic [N-1:0] prev_q;
  logic [N-1:0] sync_in;
  logic [N-1:0] clr_mask;
  logic [N-1:0] pend_set;
  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [NUM_PORTS-1:0] hit;

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Out-of-range sel matches no port, so writes and reads fall through.
  always_comb begin
    hit      = '0;
    clr_mask = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      hit[p] = (sel == SEL_W'(p));
      if (hit[p] && clrIrq)
        clr_mask[p*WIDTH +: WIDTH] = wrData;
    end
  end

  assign pend_set = ((sync_in & ~prev_q & rise_en_q) |
                     (~sync_in & prev_q & fall_en_q)) & ~dir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      prev_q    <= '0;
      sync_q    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], padIn};
      prev_q <= sync_in;
      // set is OR-ed in after the clear, so a coincident edge survives
      pend_q <= (pend_q & ~clr_mask) | pend_set;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (hit[p]) begin
          if (ceOut)  out_q[p*WIDTH +: WIDTH]     <= wrData;
          if (ceDir)  dir_q[p*WIDTH +: WIDTH]     <= wrData;
          if (ceRise) rise_en_q[p*WIDTH +: WIDTH] <= wrData;
          if (ceFall) fall_en_q[p*WIDTH +: WIDTH] <= wrData;
        end
      end
    end
  end

  always_comb begin
    rdData = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (hit[p]) begin
        case (rdSrc)
          2'b00: rdData = (dir_q[p*WIDTH +: WIDTH] & out_q[p*WIDTH +: WIDTH]) |
                          (~dir_q[p*WIDTH +: WIDTH] & sync_in[p*WIDTH +: WIDTH]);
          2'b01: rdData = out_q[p*WIDTH +: WIDTH];
          2'b10: rdData = dir_q[p*WIDTH +: WIDTH];
          default: rdData = pend_q[p*WIDTH +: WIDTH];
        endcase
      end
    end
  end

  always_comb begin
    irqPend = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      irqPend[p] = |pend_q[p*WIDTH +: WIDTH];
  end

  assign irq    = |irqPend;
  assign padOut = out_q;
  assign padOe  = dir_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Scoreboard bench for gpio_bank (3 ports so sel=3 is out of range),
// directed scenarios followed by random traffic against a reference model.
module tb_gpio_bank;

  localparam int W  = 8;
  localparam int NP = 3;
  localparam int SS = 2;
  localparam int SW = 2;
  localparam int N  = NP * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] sel;
  logic [W-1:0]  wrData;
  logic          ceOut, ceDir, ceRise, ceFall, clrIrq;
  logic [1:0]    rdSrc;
  logic [W-1:0]  rdData;
  logic [N-1:0]  padIn, padOut, padOe;
  logic [NP-1:0] irqPend;
  logic          irq;

  always #5 clk = ~clk;

  gpio_bank #(
    .WIDTH(W), .NUM_PORTS(NP), .SYNC_STAGES(SS), .SEL_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .wrData(wrData),
    .ceOut(ceOut), .ceDir(ceDir), .ceRise(ceRise), .ceFall(ceFall),
    .clrIrq(clrIrq), .rdSrc(rdSrc), .rdData(rdData), .padIn(padIn),
    .padOut(padOut), .padOe(padOe), .irqPend(irqPend), .irq(irq)
  );

  typedef struct {
    logic [W-1:0]  rd;
    logic [N-1:0]  po;
    logic [N-1:0]  oe;
    logic [NP-1:0] ip;
    logic          i;
  } exp_t;

  exp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] m_out[NP], m_dir[NP], m_re[NP], m_fe[NP], m_pend[NP];
  logic [N-1:0] hist[$];

  function automatic exp_t predict();
    exp_t e;
    logic [N-1:0] sy;
    sy = hist[SS-1];
    e.rd = '0;
    for (int p = 0; p < NP; p++) begin
      e.po[p*W +: W] = m_out[p];
      e.oe[p*W +: W] = m_dir[p];
      e.ip[p] = (m_pend[p] != 0);
    end
    e.i = (e.ip != 0);
    if (int'(sel) < NP) begin
      for (int b = 0; b < W; b++) begin
        case (rdSrc)
          2'd0: e.rd[b] = m_dir[sel][b] ? m_out[sel][b] : sy[int'(sel)*W + b];
          2'd1: e.rd[b] = m_out[sel][b];
          2'd2: e.rd[b] = m_dir[sel][b];
          default: e.rd[b] = m_pend[sel][b];
        endcase
      end
    end
    return e;
  endfunction

  task automatic model_edge();
    logic [N-1:0] s, pv;
    logic [W-1:0] clr, set;
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        m_out[p] = 0; m_dir[p] = 0; m_re[p] = 0; m_fe[p] = 0; m_pend[p] = 0;
      end
      foreach (hist[i]) hist[i] = '0;
      return;
    end
    s  = hist[SS-1];
    pv = hist[SS];
    for (int p = 0; p < NP; p++) begin
      clr = (clrIrq && int'(sel) == p) ? wrData : '0;
      for (int b = 0; b < W; b++) begin
        set[b] = !m_dir[p][b] &&
          (( s[p*W+b] && !pv[p*W+b] && m_re[p][b]) ||
           (!s[p*W+b] &&  pv[p*W+b] && m_fe[p][b]));
      end
      m_pend[p] = (m_pend[p] & ~clr) | set;
    end
    if (int'(sel) < NP) begin
      if (ceOut)  m_out[sel] = wrData;
      if (ceDir)  m_dir[sel] = wrData;
      if (ceRise) m_re[sel]  = wrData;
      if (ceFall) m_fe[sel]  = wrData;
    end
    hist.push_front(padIn);
    void'(hist.pop_back());
  endtask

  // Inputs are set at posedge+1; expectation for this cycle is queued,
  // then the model advances on the edge and strobes drop back to idle.
  task automatic tick();
    sbq.push_back(predict());
    @(posedge clk);
    model_edge();
    #1;
    rst = 0; ceOut = 0; ceDir = 0; ceRise = 0; ceFall = 0; clrIrq = 0;
  endtask

  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", n, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      vectors++;
      if (rdData !== e.rd || padOut !== e.po || padOe !== e.oe ||
          irqPend !== e.ip || irq !== e.i) begin
        miscompares++;
        $display("FAIL sb t=%0t: rd %h/%h out %h/%h oe %h/%h ip %b/%b irq %b/%b",
                 $time, rdData, e.rd, padOut, e.po, padOe, e.oe,
                 irqPend, e.ip, irq, e.i);
      end
    end
  end

  initial begin
    for (int i = 0; i <= SS; i++) hist.push_back('0);
    rst = 1; sel = 0; wrData = 0; ceOut = 0; ceDir = 0;
    ceRise = 0; ceFall = 0; clrIrq = 0; rdSrc = 0; padIn = '0;
    @(posedge clk);
    model_edge();
    #1;
    rst = 0;
    tick(); tick();
    chk("reset_oe", 32'(padOe), 0);
    chk("reset_irq", 32'(irq), 0);

    sel = 1; wrData = 8'hF0; ceDir = 1; ceOut = 1;
    tick();
    wrData = 8'hA5; ceOut = 1;
    tick();
    chk("oe_p1", 32'(padOe[15:8]), 32'hF0);
    chk("out_p1", 32'(padOut[15:8]), 32'hA5);
    rdSrc = 0; padIn[15:8] = 8'h03;
    tick(); tick();
    #1 chk("pin_p1", 32'(rdData), 32'hA3);

    sel = 0; wrData = 8'h01; ceRise = 1; rdSrc = 3;
    tick();
    padIn[0] = 1;
    tick(); tick();
    chk("irq_t2", 32'(irq), 0);
    tick();
    chk("irq_t3", 32'(irq), 1);
    padIn[0] = 0;
    repeat (4) tick();
    chk("fall_no_en", 32'(irqPend), 1);

    padIn[0] = 1;
    tick(); tick();
    wrData = 8'h01; clrIrq = 1;
    tick();
    chk("set_wins", 32'(irqPend[0]), 1);
    wrData = 8'h01; clrIrq = 1;
    tick();
    chk("clr_quiet", 32'(irq), 0);

    wrData = 8'h0F; ceDir = 1;
    tick();
    wrData = 8'hFF; ceRise = 1; ceFall = 1;
    tick();
    for (int k = 0; k < 6; k++) begin
      padIn[3:0] = 4'(k[0] ? 4'hF : 4'h0);
      tick();
    end
    chk("out_dir_no_pend", 32'(irqPend), 0);

    sel = 2; wrData = 8'hFF; ceRise = 1;
    tick();
    padIn[23:16] = 8'hFF;
    repeat (3) tick();
    chk("p2_pend", 32'(irqPend), 32'b100);
    rst = 1; ceOut = 1; wrData = 8'h55;
    tick();
    chk("rst_out", 32'(padOut), 0);
    chk("rst_irq", 32'(irq), 0);
    repeat (4) tick();
    chk("held_high_no_irq", 32'(irq), 0);

    sel = 3; wrData = 8'hFF; ceOut = 1; ceDir = 1;
    tick();
    chk("oor_out", 32'(padOut), 0);
    for (int r = 0; r < 4; r++) begin
      rdSrc = 2'(r);
      tick();
    end

    for (int k = 0; k < 600; k++) begin
      sel    = 2'($urandom_range(0, 3));
      wrData = 8'($urandom);
      ceOut  = ($urandom_range(0, 3) == 0);
      ceDir  = ($urandom_range(0, 5) == 0);
      ceRise = ($urandom_range(0, 3) == 0);
      ceFall = ($urandom_range(0, 3) == 0);
      clrIrq = ($urandom_range(0, 3) == 0);
      rdSrc  = 2'($urandom);
      if ($urandom_range(0, 2) == 0) padIn = N'($urandom) ^ padIn;
      rst    = ($urandom_range(0, 99) == 0);
      tick();
    end

    for (int k = 0; k < 4 && sbq.size() > 0; k++) @(negedge clk);
    #1;
    chk("sb_drained", 32'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
